mem_port_arbiter: RTL
=====================

// Module: mem_port_arbiter
// PURPOSE
//  Shares one byte-wide memory between the CPU instruction-fetch port and the CPU data port.
//  A fetch is sequenced as four byte beats and assembled into one 32-bit instruction.
//  A data access is a single byte read or write.
//  Sits between cpu (PC/fetch and the ALU/reg_file datapath) and the unified memory model.
//  Both requesters are stalled through BUSYWAIT.
// PARAMETERS
//  AW         8  memory address width; all addresses wrap modulo 2^AW
//  STARVE_MAX 4  max consecutive data grants while IF_REQ is pending before fetch is forced
// PORTS
//  CLK         in   1   clock, rising edge
//  RESET_N     in   1   asynchronous, active-low reset
//  IF_REQ      in   1   fetch request; held until IF_BUSYWAIT is sampled low
//  IF_ADDR     in   AW  fetch byte address (PC); held stable with IF_REQ
//  IF_INSTR    out  32  assembled instruction, registered
//  IF_BUSYWAIT out  1   fetch stall
//  D_READ      in   1   data read request
//  D_WRITE     in   1   data write request
//  D_ADDR      in   AW  data byte address
//  D_WDATA     in   8   write data
//  D_RDATA     out  8   read data, registered
//  D_BUSYWAIT  out  1   data stall
//  M_READ      out  1   memory read strobe, registered
//  M_WRITE     out  1   memory write strobe, registered
//  M_ADDR      out  AW  memory address, registered
//  M_WDATA     out  8   memory write data, registered
//  M_RDATA     in   8   memory read data; valid when a read beat completes
//  M_BUSYWAIT  in   1   memory stall
// BEHAVIOUR
//  Reset (RESET_N low, async):
//   - FSM goes to IDLE; beat counter and starve counter clear.
//   - IF_INSTR, D_RDATA, M_* are 0; both BUSYWAITs forced 0.
//   - Reset mid-beat drops the strobe immediately. No partial result is kept.
//  FSM states:
//   - IDLE  : arbitrate; no strobe.
//   - DATA  : single beat.
//   - FETCH : beats 0..3.
//   - DONE_D, DONE_F : one-cycle response.
//  Arbitration (in IDLE):
//   - Data beats fetch.
//   - Exception: fetch wins when starve_cnt == STARVE_MAX and IF_REQ is high.
//   - starve_cnt increments per data grant while IF_REQ is high; clears on fetch grant or when IF_REQ is low.
//  Data request: D_WRITE has precedence; D_READ together with D_WRITE is treated as a write.
//  Beat completion:
//   - A beat completes at the rising edge where the strobe is high and M_BUSYWAIT is low.
//   - Strobe, M_ADDR and M_WDATA stay stable until completion.
//   - Exactly one memory write occurs per D_WRITE transaction.
//  Fetch sequencing:
//   - Beat k reads IF_ADDR+k (mod 2^AW).
//   - Little-endian: byte k is stored into IF_INSTR[8k+7:8k].
//   - IF_INSTR updates only on the final beat; partial bytes go to a shadow register.
//  Responses:
//   - DONE_x lasts exactly one cycle; in it the owner's BUSYWAIT is 0.
//   - The requester samples BUSYWAIT low at that edge and advances. FSM returns to IDLE.
//  BUSYWAIT (combinational):
//   - Equals the request level, except forced 0 in the owner's DONE cycle.
//   - A new request in IDLE therefore stalls in the same cycle it is raised.
//  Latency with a zero-wait memory, request raised in cycle 0:
//   - data: BUSYWAIT low in cycle 2;
//   - fetch: BUSYWAIT low in cycle 5;
//   - plus one cycle per M_BUSYWAIT cycle.
//  Request dropped mid-transaction: the transaction still completes (a write is never aborted). The result is discarded, then the FSM returns to IDLE.
//  Read data persistence: D_RDATA holds the last read value; D_WRITE does not change it.
// STRUCTURE
//  Shared include mem_defs.v holds:
//   - state encodings: IDLE, DATA, FETCH, DONE_D, DONE_F;
//   - beat count constant 4.
//  One natural sub-module: instr_assembler.
//   - Byte-lane shadow register plus final-beat commit to IF_INSTR.
//   - Beat counter and arbitration stay in the top.
// TESTING
//  1 Reset mid-fetch (beat 2), RESET_N low:
//    -> M_READ=0 and IF_INSTR=0 without waiting for a clock.
//    -> After release, the held IF_REQ restarts at beat 0, address IF_ADDR.
//  2 Zero-wait fetch, IF_ADDR=0x10, mem[10..13]=02,01,03,00:
//    -> IF_INSTR=32'h00030102.
//    -> IF_BUSYWAIT low in cycle 5, high in cycles 0-4.
//  3 IF_REQ and D_READ raised together, D_ADDR=0x40, mem=0xAB:
//    -> Data beat first; D_RDATA=0xAB.
//    -> Fetch beat 0 strobes two cycles later; IF_BUSYWAIT stays high throughout.
//  4 IF_REQ held, 6 back-to-back D_READs, STARVE_MAX=4:
//    -> Fetch granted after the 4th data completion.
//    -> Remaining reads are served after DONE_F.
//  5 D_WRITE 0x05 to 0x20 with M_BUSYWAIT high 2 cycles:
//    -> M_WRITE=1, M_ADDR=0x20, M_WDATA=0x05 held 3 cycles.
//    -> One write only; D_BUSYWAIT low in the DONE_D cycle.
//  6 Fetch at IF_ADDR=0xFE, AW=8:
//    -> Beat addresses FE, FF, 00, 01.
//    -> IF_INSTR assembled in that byte order.

Source files
------------

// File: rtl/mem_port_arbiter_pkg.sv
// Shared definitions for the fetch/data memory port arbiter.
package mem_port_arbiter_pkg;

  // Arbiter sequencing states
  typedef enum logic [2:0] {
    IDLE,
    DATA,
    FETCH,
    DONE_D,
    DONE_F
  } state_t;

  // One instruction is fetched as this many byte beats
  localparam int unsigned BEATS  = 4;
  localparam int unsigned BEAT_W = 2;

endpackage

// File: rtl/mem_port_arbiter_instr_assembler.sv
// Collects fetch bytes into a shadow register and commits the whole
// little-endian instruction on the final beat only.
import mem_port_arbiter_pkg::*;

module instr_assembler (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              beat_done,
  input  logic [BEAT_W-1:0] beat,
  input  logic              commit_en,
  input  logic [7:0]        rdata,
  output logic [31:0]       instr
);

  logic [23:0] shadow;

  // Store bytes 0..2 into their lanes; byte 3 completes and commits the word
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow <= '0;
      instr  <= '0;
    end else if (beat_done) begin
      case (beat)
        2'd0:    shadow[7:0]   <= rdata;
        2'd1:    shadow[15:8]  <= rdata;
        2'd2:    shadow[23:16] <= rdata;
        default: if (commit_en) instr <= {rdata, shadow};
      endcase
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one byte-wide memory between the instruction-fetch port (4-beat
// fetch) and the data port (single byte read/write).
import mem_port_arbiter_pkg::*;

module mem_port_arbiter #(
  parameter int unsigned AW         = 8,
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic          CLK,
  input  logic          RESET_N,
  input  logic          IF_REQ,
  input  logic [AW-1:0] IF_ADDR,
  output logic [31:0]   IF_INSTR,
  output logic          IF_BUSYWAIT,
  input  logic          D_READ,
  input  logic          D_WRITE,
  input  logic [AW-1:0] D_ADDR,
  input  logic [7:0]    D_WDATA,
  output logic [7:0]    D_RDATA,
  output logic          D_BUSYWAIT,
  output logic          M_READ,
  output logic          M_WRITE,
  output logic [AW-1:0] M_ADDR,
  output logic [7:0]    M_WDATA,
  input  logic [7:0]    M_RDATA,
  input  logic          M_BUSYWAIT
);

  localparam int unsigned SW = $clog2(STARVE_MAX + 1);

  state_t            state, state_nxt;
  logic [BEAT_W-1:0] beat;
  logic [SW-1:0]     starve_cnt;
  logic              grant_d, grant_f;
  logic              beat_done, last_beat, d_req;

  assign d_req     = D_READ | D_WRITE;
  assign beat_done = (M_READ | M_WRITE) & ~M_BUSYWAIT;
  assign last_beat = (beat == BEAT_W'(BEATS - 1));

  // Stall each requester while its request is up, except in its DONE cycle
  assign IF_BUSYWAIT = RESET_N & IF_REQ & (state != DONE_F);
  assign D_BUSYWAIT  = RESET_N & d_req & (state != DONE_D);

  // State register
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) state <= IDLE;
    else          state <= state_nxt;
  end

  // Next state and grants; data wins unless fetch has been starved too long
  always_comb begin
    state_nxt = state;
    grant_d   = 1'b0;
    grant_f   = 1'b0;
    case (state)
      IDLE: begin
        if (IF_REQ && starve_cnt == SW'(STARVE_MAX)) grant_f = 1'b1;
        else if (d_req)                                grant_d = 1'b1;
        else if (IF_REQ)                               grant_f = 1'b1;
        if (grant_d)      state_nxt = DATA;
        else if (grant_f) state_nxt = FETCH;
      end
      DATA:    if (beat_done) state_nxt = DONE_D;
      FETCH:   if (beat_done && last_beat) state_nxt = DONE_F;
      DONE_D:  state_nxt = IDLE;
      DONE_F:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Count data grants taken while a fetch is waiting
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N)                starve_cnt <= '0;
    else if (!IF_REQ || grant_f) starve_cnt <= '0;
    else if (grant_d)            starve_cnt <= starve_cnt + SW'(1);
  end

  // Memory strobes, beat sequencing and data read capture
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      beat    <= '0;
      M_READ  <= 1'b0;
      M_WRITE <= 1'b0;
      M_ADDR  <= '0;
      M_WDATA <= '0;
      D_RDATA <= '0;
    end else if (grant_d) begin
      M_WRITE <= D_WRITE;
      M_READ  <= ~D_WRITE;
      M_ADDR  <= D_ADDR;
      M_WDATA <= D_WDATA;
    end else if (grant_f) begin
      beat   <= '0;
      M_READ <= 1'b1;
      M_ADDR <= IF_ADDR;
    end else if (beat_done) begin
      if (state == FETCH && !last_beat) begin
        beat   <= beat + BEAT_W'(1);
        M_ADDR <= M_ADDR + AW'(1);
      end else begin
        M_READ  <= 1'b0;
        M_WRITE <= 1'b0;
      end
      // A read whose request was withdrawn mid-beat is discarded
      if (state == DATA && !M_WRITE && D_READ && !D_WRITE) D_RDATA <= M_RDATA;
    end
  end

  instr_assembler u_asm (
    .clk       (CLK),
    .rst_n     (RESET_N),
    .beat_done (beat_done && state == FETCH),
    .beat      (beat),
    .commit_en (IF_REQ),
    .rdata     (M_RDATA),
    .instr     (IF_INSTR)
  );

endmodule
